ysyx_040066_mem_arbiter: RTL

Two-to-one memory arbiter between the CPU core's instruction-fetch port and data port, and the single downstream 64-bit memory bus. It sits between the core top and the bus bridge.
- Serializes one outstanding transaction at a time, with round-robin priority.
- Converts the core's level-held requests into a registered req/ack bus handshake.
- Returns single-cycle `valid` pulses to the core.
- Bounds every bus transaction with a timeout that reports an error.

---
 rtl/ysyx_040066_mem_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_040066_mem_arbiter.sv
// Two-to-one arbiter: instruction-fetch and data ports onto one 64-bit req/ack bus.
// One transaction in flight, round-robin on contention, timeout-bounded, registered outputs.
module ysyx_040066_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [63:0] pc_rd,
  output logic [31:0] instr_rd,
  output logic        instr_valid,
  output logic        instr_error,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [63:0] addr,
  input  logic [63:0] data_Wr,
  input  logic [7:0]  wr_mask,
  input  logic [2:0]  wr_len,
  output logic [63:0] data_Rd,
  output logic        data_valid,
  output logic        data_error,
  output logic        bus_req,
  output logic        bus_wen,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wmask,
  output logic [2:0]  bus_len,
  input  logic        bus_ack,
  input  logic [63:0] bus_rdata,
  input  logic        bus_err
);

  // Handshake: bus_req rises one cycle after a grant and holds with all bus fields
  // stable until the one-cycle bus_ack (or timeout); the core holds its request level
  // until the matching one-cycle valid pulse, which it must treat as completion.
  typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} state_t;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_t           state, next_state;
  logic             last_d, last_d_n;
  logic             cancel, cancel_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic        bus_req_n, bus_wen_n;
  logic [63:0] bus_addr_n, bus_wdata_n;
  logic [7:0]  bus_wmask_n;
  logic [2:0]  bus_len_n;
  logic        instr_valid_n, instr_error_n;
  logic [31:0] instr_rd_n;
  logic        data_valid_n, data_error_n;
  logic [63:0] data_Rd_n;

  logic        d_pend, pick_d, in_bus, timed_out, bus_done, fetch_stale;
  logic [63:0] cap_data;
  logic        cap_err;

  assign d_pend      = MemRd | MemWr;
  assign pick_d      = d_pend & ~(instr_read & last_d);
  assign in_bus      = (state == IBUS) || (state == DBUS);
  assign timed_out   = (TIMEOUT != 0) && (cnt == TO_VAL);
  assign bus_done    = in_bus & (bus_ack | timed_out);
  // The core abandoned or redirected the fetch; the bus cycle still has to finish.
  assign fetch_stale = (state == IBUS) & (~instr_read | (pc_rd != bus_addr));
  // Ack wins over a coincident timeout.
  assign cap_data    = bus_ack ? bus_rdata : 64'd0;
  assign cap_err     = bus_ack ? bus_err : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (pick_d)          next_state = DBUS;
        else if (instr_read) next_state = IBUS;
      end
      IBUS, DBUS: if (bus_ack || timed_out) next_state = RESP;
      RESP:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    bus_req_n     = (next_state == IBUS) || (next_state == DBUS);
    bus_wen_n     = bus_wen;
    bus_addr_n    = bus_addr;
    bus_wdata_n   = bus_wdata;
    bus_wmask_n   = bus_wmask;
    bus_len_n     = bus_len;
    last_d_n      = last_d;
    cancel_n      = cancel;
    cnt_n         = cnt;
    instr_valid_n = 1'b0;
    instr_rd_n    = instr_rd;
    instr_error_n = instr_error;
    data_valid_n  = 1'b0;
    data_Rd_n     = data_Rd;
    data_error_n  = data_error;
    unique case (state)
      IDLE: begin
        if (pick_d) begin
          bus_wen_n   = MemWr;
          bus_addr_n  = addr;
          bus_wdata_n = data_Wr;
          bus_wmask_n = wr_mask;
          bus_len_n   = wr_len;
          last_d_n    = 1'b1;
          cnt_n       = '0;
        end else if (instr_read) begin
          bus_wen_n   = 1'b0;
          bus_addr_n  = pc_rd;
          bus_wdata_n = 64'd0;
          bus_wmask_n = 8'd0;
          bus_len_n   = 3'd2;
          last_d_n    = 1'b0;
          cnt_n       = '0;
        end
      end
      IBUS, DBUS: begin
        cnt_n = cnt + CNT_W'(1);
        if (fetch_stale) cancel_n = 1'b1;
        if (bus_done) begin
          if (state == DBUS) begin
            data_valid_n = 1'b1;
            data_Rd_n    = cap_data;
            data_error_n = cap_err;
          end else if (!(cancel || fetch_stale)) begin
            instr_valid_n = 1'b1;
            instr_rd_n    = bus_addr[2] ? cap_data[63:32] : cap_data[31:0];
            instr_error_n = cap_err;
          end
        end
      end
      RESP:    cancel_n = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d      <= 1'b0;
      cancel      <= 1'b0;
      cnt         <= '0;
      bus_req     <= 1'b0;
      bus_wen     <= 1'b0;
      bus_addr    <= 64'd0;
      bus_wdata   <= 64'd0;
      bus_wmask   <= 8'd0;
      bus_len     <= 3'd0;
      instr_valid <= 1'b0;
      instr_rd    <= 32'd0;
      instr_error <= 1'b0;
      data_valid  <= 1'b0;
      data_Rd     <= 64'd0;
      data_error  <= 1'b0;
    end else begin
      last_d      <= last_d_n;
      cancel      <= cancel_n;
      cnt         <= cnt_n;
      bus_req     <= bus_req_n;
      bus_wen     <= bus_wen_n;
      bus_addr    <= bus_addr_n;
      bus_wdata   <= bus_wdata_n;
      bus_wmask   <= bus_wmask_n;
      bus_len     <= bus_len_n;
      instr_valid <= instr_valid_n;
      instr_rd    <= instr_rd_n;
      instr_error <= instr_error_n;
      data_valid  <= data_valid_n;
      data_Rd     <= data_Rd_n;
      data_error  <= data_error_n;
    end
  end

endmodule
